fetch_ctrl: RTL and testbench

//  Sequences the fetch stage: drives PC load enable and next-PC select, runs the imem req/ack handshake,
//  and controls the IF/ID register (load, flush, skid buffer).

---
 rtl/fetch_ctrl_pkg.sv | 39 +++
 rtl/fetch_ctrl_sat_counter.sv | 18 +
 rtl/fetch_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: next-PC select codes, controller states and
// the redirect priority encoder used by the PC mux and decode.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        PCSEL_SEQ = 3'd0,
        PCSEL_BR  = 3'd1,
        PCSEL_J   = 3'd2,
        PCSEL_JR  = 3'd3,
        PCSEL_EXC = 3'd4
    } pc_sel_e;

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_REQ  = 3'd1,
        S_HELD = 3'd2,
        S_DROP = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    // Overlapping redirects are legal; exceptions win, then J, branch, JR.
    function automatic pc_sel_e redirect_sel(input logic exc_req,
                                             input logic jump,
                                             input logic branch,
                                             input logic jump_reg);
        pc_sel_e sel;
        sel = PCSEL_SEQ;
        if (exc_req)
            sel = PCSEL_EXC;
        else if (jump)
            sel = PCSEL_J;
        else if (branch)
            sel = PCSEL_BR;
        else if (jump_reg)
            sel = PCSEL_JR;
        return sel;
    endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC load/select, imem req/ack handshake, IF/ID load,
// flush and skid-buffer control, wrong-path discard and imem timeout detection.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump,
    input  logic             branch,
    input  logic             jump_reg,
    input  logic             exc_req,
    input  logic             ld_use_stall,
    input  logic             imem_ack,
    output logic             imem_req,
    output logic             pc_en,
    output logic [2:0]       pc_sel,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             ibuf_ld,
    output logic             fd_from_buf,
    output logic             imem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int             WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_e            state;
    state_e            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic              timeout_q;
    logic              redirect;
    pc_sel_e           rsel;
    logic              stall_inc;

    assign redirect = exc_req | jump | branch | jump_reg;
    assign rsel     = redirect_sel(exc_req, jump, branch, jump_reg);

    // Redirects always outrank the load-use stall; a fetch still in flight
    // when a redirect arrives is wrong-path and is drained in S_DROP.
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = PCSEL_SEQ;
        fd_en       = 1'b0;
        fd_flush    = 1'b0;
        ibuf_ld     = 1'b0;
        fd_from_buf = 1'b0;

        case (state)
            S_RST: begin
                state_next = S_REQ;
            end

            S_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pc_en      = 1'b1;
                    pc_sel     = rsel;
                    fd_flush   = 1'b1;
                    state_next = imem_ack ? S_REQ : S_DROP;
                end else if (imem_ack && !ld_use_stall) begin
                    pc_en = 1'b1;
                    fd_en = 1'b1;
                end else if (imem_ack) begin
                    pc_en      = 1'b1;
                    ibuf_ld    = 1'b1;
                    state_next = S_HELD;
                end else if (wait_cnt == WAIT_MAX) begin
                    state_next = S_ERR;
                end
            end

            S_HELD: begin
                if (redirect) begin
                    pc_en      = 1'b1;
                    pc_sel     = rsel;
                    fd_flush   = 1'b1;
                    state_next = S_REQ;
                end else if (!ld_use_stall) begin
                    fd_en       = 1'b1;
                    fd_from_buf = 1'b1;
                    state_next  = S_REQ;
                end
            end

            S_DROP: begin
                // A redirect that coincides with the wrong-path ack ends the
                // drain; the new request then starts at the redirected PC.
                imem_req = 1'b1;
                if (redirect) begin
                    pc_en      = 1'b1;
                    pc_sel     = rsel;
                    fd_flush   = 1'b1;
                    state_next = imem_ack ? S_REQ : S_DROP;
                end else if (imem_ack) begin
                    state_next = S_REQ;
                end else if (wait_cnt == WAIT_MAX) begin
                    state_next = S_ERR;
                end
            end

            S_ERR: begin
                state_next = S_ERR;
            end

            default: begin
                state_next = S_RST;
            end
        endcase
    end

    // Wait counter tracks unacknowledged cycles of the current transaction.
    always_comb begin
        wait_next = '0;
        if ((state == S_REQ || state == S_DROP) && state_next == state && !imem_ack)
            wait_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RST;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if (state_next == S_ERR)
                timeout_q <= 1'b1;
        end
    end

    assign imem_timeout = timeout_q;

    assign stall_inc = (state == S_REQ || state == S_HELD || state == S_DROP) && !pc_en;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_inc),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl: expectations are queued with each
// stimulus step and popped when the outputs are sampled mid-cycle.
module tb_fetch_ctrl;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 16;

    // Redirect vector layout: {exc_req, jump, branch, jump_reg}
    localparam logic [3:0] R_NONE = 4'b0000;
    localparam logic [3:0] R_JR   = 4'b0001;
    localparam logic [3:0] R_BR   = 4'b0010;
    localparam logic [3:0] R_J    = 4'b0100;

    logic             clk;
    logic             rst;
    logic             jump;
    logic             branch;
    logic             jump_reg;
    logic             exc_req;
    logic             ld_use_stall;
    logic             imem_ack;
    logic             imem_req;
    logic             pc_en;
    logic [2:0]       pc_sel;
    logic             fd_en;
    logic             fd_flush;
    logic             ibuf_ld;
    logic             fd_from_buf;
    logic             imem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    logic [9:0] exp_q[$];
    string      tag_q[$];
    int         n_checks;
    int         n_fail;

    fetch_ctrl #(
        .MAX_WAIT(MAX_WAIT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jump        (jump),
        .branch      (branch),
        .jump_reg    (jump_reg),
        .exc_req     (exc_req),
        .ld_use_stall(ld_use_stall),
        .imem_ack    (imem_ack),
        .imem_req    (imem_req),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .fd_en       (fd_en),
        .fd_flush    (fd_flush),
        .ibuf_ld     (ibuf_ld),
        .fd_from_buf (fd_from_buf),
        .imem_timeout(imem_timeout),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {imem_req, pc_en, pc_sel, fd_en, fd_flush, ibuf_ld, fd_from_buf, imem_timeout}
    function automatic logic [9:0] mk(input logic req, input logic pen, input logic [2:0] sel,
                                      input logic fen, input logic fl, input logic ib,
                                      input logic fb, input logic tmo);
        return {req, pen, sel, fen, fl, ib, fb, tmo};
    endfunction

    task automatic apply_stimulus(input logic [3:0] rdr, input logic stall, input logic ack,
                                  input logic [9:0] e, input string tag);
        exc_req      = rdr[3];
        jump         = rdr[2];
        branch       = rdr[1];
        jump_reg     = rdr[0];
        ld_use_stall = stall;
        imem_ack     = ack;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_output();
        logic [9:0] e;
        logic [9:0] obs;
        string      tag;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_empty: observed 0 entries required 1");
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            obs = {imem_req, pc_en, pc_sel, fd_en, fd_flush, ibuf_ld, fd_from_buf, imem_timeout};
            assert (obs === e) else begin
                n_fail++;
                $error("[TB] FAIL %s: observed %b required %b", tag, obs, e);
            end
        end
    endtask

    task automatic check_cnt(input logic [CNT_W-1:0] e, input string tag);
        n_checks++;
        assert (stall_cnt === e) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed stall_cnt %0d required %0d", tag, stall_cnt, e);
        end
    endtask

    // One clock cycle: drive just after the edge, compare at the falling edge.
    task automatic step(input logic [3:0] rdr, input logic stall, input logic ack,
                        input logic [9:0] e, input string tag);
        apply_stimulus(rdr, stall, ack, e, tag);
        @(negedge clk);
        check_output();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] idle;
        logic [9:0] req_only;
        logic [9:0] fetch;
        logic [9:0] err;

        idle     = mk(0, 0, 3'd0, 0, 0, 0, 0, 0);
        req_only = mk(1, 0, 3'd0, 0, 0, 0, 0, 0);
        fetch    = mk(1, 1, 3'd0, 1, 0, 0, 0, 0);
        err      = mk(0, 0, 3'd0, 0, 0, 0, 0, 1);
        n_checks = 0;
        n_fail   = 0;

        rst = 1'b1;
        apply_stimulus(R_NONE, 1'b0, 1'b1, idle, "in_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output();
        check_cnt('0, "cnt_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        step(R_NONE, 1'b0, 1'b1, idle, "rst_state_stray_ack");
        for (int i = 0; i < 3; i++)
            step(R_NONE, 1'b0, 1'b1, fetch, "seq_fetch");
        check_cnt('0, "cnt_after_fetch");

        // Branch while the fetch is outstanding: wrong-path drain in S_DROP.
        step(R_BR, 1'b0, 1'b0, mk(1, 1, 3'd1, 0, 1, 0, 0, 0), "branch_redirect");
        step(R_NONE, 1'b0, 1'b0, req_only, "drop_wait1");
        step(R_NONE, 1'b0, 1'b0, req_only, "drop_wait2");
        step(R_NONE, 1'b0, 1'b1, req_only, "drop_ack_discard");
        step(R_NONE, 1'b0, 1'b1, fetch, "new_req");
        check_cnt(16'd3, "cnt_after_drop");

        // Load-use stall: capture into skid buffer, hold, then release from it.
        step(R_NONE, 1'b1, 1'b1, mk(1, 1, 3'd0, 0, 0, 1, 0, 0), "stall_capture");
        step(R_NONE, 1'b1, 1'b0, idle, "held");
        step(R_NONE, 1'b0, 1'b0, mk(0, 0, 3'd0, 1, 0, 0, 1, 0), "buf_release");
        check_cnt(16'd5, "cnt_after_stall");

        step(4'b1110, 1'b0, 1'b1, mk(1, 1, 3'd4, 0, 1, 0, 0, 0), "prio_exc");
        step(4'b0101, 1'b0, 1'b1, mk(1, 1, 3'd2, 0, 1, 0, 0, 0), "prio_jump");
        step(R_BR, 1'b1, 1'b1, mk(1, 1, 3'd1, 0, 1, 0, 0, 0), "redirect_over_stall");
        step(R_JR, 1'b0, 1'b1, mk(1, 1, 3'd3, 0, 1, 0, 0, 0), "sel_jr");
        step(R_NONE, 1'b1, 1'b1, mk(1, 1, 3'd0, 0, 0, 1, 0, 0), "stall_capture2");
        step(R_J, 1'b1, 1'b0, mk(0, 1, 3'd2, 0, 1, 0, 0, 0), "held_redirect");
        step(R_NONE, 1'b0, 1'b1, fetch, "fetch_after_held");
        check_cnt(16'd5, "cnt_after_redirects");

        // Starve imem: MAX_WAIT+1 unacknowledged cycles trip the timeout.
        for (int i = 0; i <= MAX_WAIT; i++)
            step(R_NONE, 1'b0, 1'b0, req_only, "timeout_wait");
        step(R_NONE, 1'b0, 1'b1, err, "err_state");
        step(R_BR, 1'b0, 1'b1, err, "err_sticky");
        check_cnt(16'd21, "cnt_after_timeout");

        rst = 1'b1;
        apply_stimulus(R_NONE, 1'b0, 1'b1, idle, "err_reset");
        #1;
        check_output();
        check_cnt('0, "cnt_err_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(R_NONE, 1'b0, 1'b0, idle, "post_rst");

        // Asynchronous reset in the middle of a wrong-path drain.
        step(R_BR, 1'b0, 1'b0, mk(1, 1, 3'd1, 0, 1, 0, 0, 0), "branch_redirect2");
        step(R_NONE, 1'b0, 1'b0, req_only, "drop_wait3");
        rst = 1'b1;
        apply_stimulus(R_NONE, 1'b0, 1'b1, idle, "rst_mid_drop");
        #1;
        check_output();
        #1;
        rst = 1'b0;
        apply_stimulus(R_NONE, 1'b0, 1'b1, idle, "stray_ack_after_rst");
        @(negedge clk);
        check_output();
        check_cnt('0, "cnt_rst_mid_drop");
        @(posedge clk);
        #1;
        step(R_NONE, 1'b0, 1'b1, fetch, "resume_fetch");
        step(R_NONE, 1'b0, 1'b1, fetch, "resume_fetch2");
        check_cnt('0, "cnt_resume");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
